// File: rtl/cache_assoc_fill.sv
// ---------------------------------------------------------------------------
// cache_assoc_fill
//   N-way set-associative, write-allocate data cache for the MEM stage with
//   per-set age-based LRU and a built-in miss handler. On a miss the handler
//   streams a whole block in over a pipelined word-read port, then installs it.
//   Writes update only the local arrays; write-through is handled upstream.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid       MEM-stage access present (held stable while stall=1)
//   req_wr          1 = store, 0 = load
//   req_addr        byte address
//   req_wdata       store data
//   rdata           hit word (combinational), 0 when not hitting
//   hit             lookup hit (combinational)
//   stall           pipeline freeze
//   mem_rd_req      word-read issue strobe toward memory
//   mem_rd_addr     word-read byte address
//   mem_rd_data     returned word
//   mem_rd_valid    returned word valid (in issue order, fixed latency)
//   miss_count      saturating miss counter
//
// Address layout (low to high): byte offset | word in block | set index | tag.
// BLK_WORDS and SETS are expected to be at least 2.
// ---------------------------------------------------------------------------
module cache_assoc_fill #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int BLK_WORDS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic [15:0]           miss_count
);

  localparam int BYTE_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 0;
  localparam int WORD_W = $clog2(BLK_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - WORD_W - BYTE_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W  = WAY_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Metadata and data storage
  logic                  r_valid  [WAYS][SETS];
  logic [TAG_W-1:0]      r_tagMem [WAYS][SETS];
  logic [AGE_W-1:0]      r_age    [SETS][WAYS];
  logic [DATA_WIDTH-1:0] r_data   [WAYS][SETS][BLK_WORDS];

  // Miss-handler context
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_index;
  logic [WAY_W-1:0]  r_victim;
  logic [WORD_W:0]   r_issueCnt;
  logic [WORD_W-1:0] r_rcvCnt;
  logic [15:0]       r_missCount;

  // Request fields
  logic [WORD_W-1:0] w_word;
  logic [IDX_W-1:0]  w_index;
  logic [TAG_W-1:0]  w_tag;

  logic [WAYS-1:0]   w_wayHit;
  logic              w_anyHit;
  logic [WAY_W-1:0]  w_hitWay;
  logic              w_hit;
  logic [WAY_W-1:0]  w_victim;
  logic              w_foundInvalid;
  logic              w_missStart;
  logic              w_lastResp;

  logic              w_lruEn;
  logic [IDX_W-1:0]  w_lruSet;
  logic [WAY_W-1:0]  w_lruWay;

  assign w_word  = WORD_W'(req_addr >> BYTE_W);
  assign w_index = IDX_W'(req_addr >> (BYTE_W + WORD_W));
  assign w_tag   = TAG_W'(req_addr >> (BYTE_W + WORD_W + IDX_W));

  // Tag compare across all ways of the addressed set. At most one way can
  // match because a block is only installed after it has missed.
  always_comb begin
    w_wayHit = '0;
    w_hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_wayHit[w] = r_valid[w][w_index] && (r_tagMem[w][w_index] == w_tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_wayHit[w]) begin
        w_hitWay = WAY_W'(w);
      end
    end
  end

  assign w_anyHit = |w_wayHit;
  assign w_hit    = req_valid && (r_state == IDLE) && w_anyHit;
  assign hit      = w_hit;
  assign rdata    = w_hit ? r_data[w_hitWay][w_index][w_word] : '0;

  // Victim choice: fill empty ways first (lowest index), otherwise take the
  // oldest way, which is the one whose age has reached WAYS-1.
  always_comb begin
    w_victim       = '0;
    w_foundInvalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!r_valid[w][w_index] && !w_foundInvalid) begin
        w_victim       = WAY_W'(w);
        w_foundInvalid = 1'b1;
      end
    end
    if (!w_foundInvalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w_index][w] == AGE_W'(WAYS - 1)) begin
          w_victim = WAY_W'(w);
        end
      end
    end
  end

  assign w_missStart = (r_state == IDLE) && req_valid && !w_anyHit;
  assign w_lastResp  = (r_state == FILL) && mem_rd_valid &&
                       (r_rcvCnt == WORD_W'(BLK_WORDS - 1));

  // A way becomes MRU either when it hits or when a freshly filled block is
  // installed into it; both cases share the same age update.
  always_comb begin
    w_lruEn  = 1'b0;
    w_lruSet = w_index;
    w_lruWay = w_hitWay;
    if (r_state == COMMIT) begin
      w_lruEn  = 1'b1;
      w_lruSet = r_index;
      w_lruWay = r_victim;
    end else if (w_hit) begin
      w_lruEn = 1'b1;
    end
  end

  // Next-state logic and the FSM-driven outputs.
  always_comb begin
    w_nextState = r_state;
    stall       = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    case (r_state)
      IDLE: begin
        stall = req_valid && !w_anyHit;
        if (w_missStart) begin
          w_nextState = FILL;
        end
      end
      FILL: begin
        stall       = 1'b1;
        mem_rd_req  = (r_issueCnt < (WORD_W + 1)'(BLK_WORDS));
        mem_rd_addr = ADDR_WIDTH'({r_tag, r_index, r_issueCnt[WORD_W-1:0]}) << BYTE_W;
        if (w_lastResp) begin
          w_nextState = COMMIT;
        end
      end
      COMMIT: begin
        stall       = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register plus the miss-handler context: latch the missing block and
  // its victim on entry to FILL, then track issued and received words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tag       <= '0;
      r_index     <= '0;
      r_victim    <= '0;
      r_issueCnt  <= '0;
      r_rcvCnt    <= '0;
      r_missCount <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_missStart) begin
        r_tag      <= w_tag;
        r_index    <= w_index;
        r_victim   <= w_victim;
        r_issueCnt <= '0;
        r_rcvCnt   <= '0;
        if (r_missCount != 16'hFFFF) begin
          r_missCount <= r_missCount + 16'd1;
        end
      end
      if (r_state == FILL) begin
        if (mem_rd_req) begin
          r_issueCnt <= r_issueCnt + 1'b1;
        end
        if (mem_rd_valid) begin
          r_rcvCnt <= r_rcvCnt + 1'b1;
        end
      end
    end
  end

  assign miss_count = r_missCount;

  // Valid/tag/age arrays. The block only becomes visible in COMMIT, so a
  // partially received block can never produce a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[w][s]  <= 1'b0;
          r_tagMem[w][s] <= '0;
          r_age[s][w]    <= AGE_W'(w);
        end
      end
    end else begin
      if (r_state == COMMIT) begin
        r_valid[r_victim][r_index]  <= 1'b1;
        r_tagMem[r_victim][r_index] <= r_tag;
      end
      if (w_lruEn) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_lruWay) begin
            r_age[w_lruSet][w] <= '0;
          end else if (r_age[w_lruSet][w] < r_age[w_lruSet][w_lruWay]) begin
            r_age[w_lruSet][w] <= r_age[w_lruSet][w] + 1'b1;
          end
        end
      end
    end
  end

  // Data array, deliberately without reset. Fill responses and store hits
  // never coincide because hits require the IDLE state.
  always_ff @(posedge clk) begin
    if ((r_state == FILL) && mem_rd_valid) begin
      r_data[r_victim][r_index][r_rcvCnt] <= mem_rd_data;
    end else if (w_hit && req_wr) begin
      r_data[w_hitWay][w_index][w_word] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_cache_assoc_fill.sv
// ---------------------------------------------------------------------------
// tb_cache_assoc_fill
//   Self-checking bench for cache_assoc_fill. Two instances: the default
//   2-way cache and a 4-way variant for LRU depth and counter saturation.
//   Each has a memory model with latency 4 whose word at byte address a is a.
// ---------------------------------------------------------------------------
module tb_cache_assoc_fill;

  localparam int LAT       = 4;
  localparam int BLK       = 8;
  localparam int MISS_STALL = BLK + LAT + 2;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          expMiss;
    bit          chkData;
    logic [15:0] expData;
    logic [15:0] expMc;
  } vec_t;

  logic clk;
  logic rst;

  // 2-way instance signals
  logic        reqValid, reqWr;
  logic [15:0] reqAddr, reqWdata;
  logic [15:0] rdata;
  logic        hit, stall, memRdReq, memRdValid;
  logic [15:0] memRdAddr, memRdData, missCount;

  // 4-way instance signals
  logic        reqValid4, reqWr4;
  logic [15:0] reqAddr4, reqWdata4;
  logic [15:0] rdata4;
  logic        hit4, stall4, memRdReq4, memRdValid4;
  logic [15:0] memRdAddr4, memRdData4, missCount4;

  logic        strayValid;
  logic [16:0] pipe  [LAT];
  logic [16:0] pipe4 [LAT];

  int          assertions;
  int          failures;
  logic [15:0] addrQ [$];
  vec_t        expQ  [$];
  vec_t        vecs  [16];

  bit          activeSel;
  logic        curStall, curHit;
  logic [15:0] curRdata, curMc;

  assign curStall = activeSel ? stall4     : stall;
  assign curHit   = activeSel ? hit4       : hit;
  assign curRdata = activeSel ? rdata4     : rdata;
  assign curMc    = activeSel ? missCount4 : missCount;

  cache_assoc_fill #(.WAYS(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_wr(reqWr), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rdata(rdata), .hit(hit), .stall(stall),
    .mem_rd_req(memRdReq), .mem_rd_addr(memRdAddr),
    .mem_rd_data(memRdData), .mem_rd_valid(memRdValid),
    .miss_count(missCount)
  );

  cache_assoc_fill #(.WAYS(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid4), .req_wr(reqWr4), .req_addr(reqAddr4), .req_wdata(reqWdata4),
    .rdata(rdata4), .hit(hit4), .stall(stall4),
    .mem_rd_req(memRdReq4), .mem_rd_addr(memRdAddr4),
    .mem_rd_data(memRdData4), .mem_rd_valid(memRdValid4),
    .miss_count(missCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency memories: a request seen at a rising edge returns LAT
  // cycles later; the data word equals its byte address.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe[i]  <= '0;
        pipe4[i] <= '0;
      end
    end else begin
      pipe[0]  <= {memRdReq, memRdAddr};
      pipe4[0] <= {memRdReq4, memRdAddr4};
      for (int i = 1; i < LAT; i++) begin
        pipe[i]  <= pipe[i-1];
        pipe4[i] <= pipe4[i-1];
      end
    end
  end

  assign memRdValid  = pipe[LAT-1][16] | strayValid;
  assign memRdData   = pipe[LAT-1][16] ? pipe[LAT-1][15:0] : 16'hDEAD;
  assign memRdValid4 = pipe4[LAT-1][16];
  assign memRdData4  = pipe4[LAT-1][15:0];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every issued word-read of the 2-way cache is compared against the
  // address list queued when the miss was driven.
  always @(posedge clk) begin
    #1;
    if (memRdReq && !rst) begin
      if (addrQ.size() == 0) begin
        assertions++;
        failures++;
        $display("[TB] FAIL unexpectedRdReq: got addr 0x%0h, expected no request", memRdAddr);
      end else begin
        checkOutput("memRdAddr", {16'h0, memRdAddr}, {16'h0, addrQ.pop_front()});
      end
    end
  end

  // Drive one access, wait (bounded) for stall to drop, then compare the
  // completed access against the scoreboard entry queued at drive time.
  task automatic applyStimulus(input bit sel, input vec_t v, input logic [15:0] glitch);
    int   cnt;
    vec_t e;
    @(negedge clk);
    activeSel = sel;
    if (sel) begin
      reqValid4 = 1'b1; reqWr4 = v.wr; reqAddr4 = v.addr; reqWdata4 = v.wdata;
    end else begin
      reqValid = 1'b1; reqWr = v.wr; reqAddr = v.addr; reqWdata = v.wdata;
      if (v.expMiss) begin
        for (int i = 0; i < BLK; i++) begin
          addrQ.push_back((v.addr & 16'hFFF0) | 16'(i << 1));
        end
      end
    end
    expQ.push_back(v);
    #1;
    cnt = 0;
    while (curStall && cnt < 100) begin
      cnt++;
      @(negedge clk);
      if (!sel && glitch != 16'h0) begin
        reqAddr = (cnt >= 2 && cnt <= 6) ? glitch : v.addr;
      end
      #1;
    end
    e = expQ.pop_front();
    checkOutput($sformatf("stallCycles@%h", e.addr), cnt, e.expMiss ? MISS_STALL : 0);
    checkOutput($sformatf("hit@%h", e.addr), {31'h0, curHit}, 32'h1);
    if (e.chkData) begin
      checkOutput($sformatf("rdata@%h", e.addr), {16'h0, curRdata}, {16'h0, e.expData});
    end
    checkOutput($sformatf("missCount@%h", e.addr), {16'h0, curMc}, {16'h0, e.expMc});
    @(negedge clk);
    if (sel) reqValid4 = 1'b0;
    else     reqValid  = 1'b0;
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                              input bit miss, input bit chk, input logic [15:0] data,
                              input logic [15:0] mc);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.expMiss = miss;
    v.chkData = chk; v.expData = data; v.expMc = mc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   respCnt;
    int   guard;
    vec_t v;

    assertions = 0;
    failures   = 0;
    activeSel  = 1'b0;
    strayValid = 1'b0;
    reqValid = 0; reqWr = 0; reqAddr = '0; reqWdata = '0;
    reqValid4 = 0; reqWr4 = 0; reqAddr4 = '0; reqWdata4 = '0;

    // Main 2-way access table; miss_count is cumulative.
    vecs[0]  = mk(0, 16'h0006, 16'h0,    1, 1, 16'h0006, 16'd1);
    vecs[1]  = mk(0, 16'h000E, 16'h0,    0, 1, 16'h000E, 16'd1);
    vecs[2]  = mk(1, 16'h0004, 16'hBEEF, 0, 0, 16'h0,    16'd1);
    vecs[3]  = mk(0, 16'h0004, 16'h0,    0, 1, 16'hBEEF, 16'd1);
    vecs[4]  = mk(1, 16'h0020, 16'h1234, 1, 0, 16'h0,    16'd2);
    vecs[5]  = mk(0, 16'h0020, 16'h0,    0, 1, 16'h1234, 16'd2);
    vecs[6]  = mk(0, 16'h0022, 16'h0,    0, 1, 16'h0022, 16'd2);
    vecs[7]  = mk(0, 16'h0000, 16'h0,    0, 1, 16'h0000, 16'd2);
    vecs[8]  = mk(0, 16'h0400, 16'h0,    1, 1, 16'h0400, 16'd3);
    vecs[9]  = mk(0, 16'h0000, 16'h0,    0, 1, 16'h0000, 16'd3);
    vecs[10] = mk(0, 16'h0800, 16'h0,    1, 1, 16'h0800, 16'd4);
    vecs[11] = mk(0, 16'h0000, 16'h0,    0, 1, 16'h0000, 16'd4);
    vecs[12] = mk(0, 16'h0400, 16'h0,    1, 1, 16'h0400, 16'd5);
    vecs[13] = mk(0, 16'h0802, 16'h0,    1, 1, 16'h0802, 16'd6);
    vecs[14] = mk(0, 16'h040E, 16'h0,    0, 1, 16'h040E, 16'd6);
    vecs[15] = mk(0, 16'h0000, 16'h0,    1, 1, 16'h0000, 16'd7);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetStall",    {31'h0, stall},      32'h0);
    checkOutput("resetRdReq",    {31'h0, memRdReq},   32'h0);
    checkOutput("resetRdAddr",   {16'h0, memRdAddr},  32'h0);
    checkOutput("resetMissCnt",  {16'h0, missCount},  32'h0);
    checkOutput("resetHit",      {31'h0, hit},        32'h0);
    checkOutput("resetMissCnt4", {16'h0, missCount4}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] running 2-way access table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, vecs[i], 16'h0);
    end

    // Stray responses while IDLE must not touch the arrays.
    $display("[TB] stray responses outside FILL");
    @(negedge clk);
    strayValid = 1'b1;
    repeat (3) @(negedge clk);
    strayValid = 1'b0;
    applyStimulus(1'b0, mk(0, 16'h0000, 16'h0, 0, 1, 16'h0000, 16'd7), 16'h0);
    applyStimulus(1'b0, mk(0, 16'h0002, 16'h0, 0, 1, 16'h0002, 16'd7), 16'h0);

    // Address wobble during a fill: the latched block still completes.
    $display("[TB] address change during fill");
    applyStimulus(1'b0, mk(0, 16'h0C00, 16'h0, 1, 1, 16'h0C00, 16'd8), 16'h1000);
    applyStimulus(1'b0, mk(0, 16'h0C0E, 16'h0, 0, 1, 16'h0C0E, 16'd8), 16'h0);

    // Reset during the third response of a fill.
    $display("[TB] reset mid-fill");
    @(negedge clk);
    reqValid = 1'b1; reqWr = 1'b0; reqAddr = 16'h2000;
    for (int i = 0; i < BLK; i++) begin
      addrQ.push_back(16'h2000 | 16'(i << 1));
    end
    respCnt = 0;
    guard   = 0;
    while (respCnt < 3 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (memRdValid) respCnt++;
    end
    checkOutput("respBeforeReset", respCnt, 3);
    rst      = 1'b1;
    reqValid = 1'b0;
    #1;
    checkOutput("midFillStall",   {31'h0, stall},     32'h0);
    checkOutput("midFillRdReq",   {31'h0, memRdReq},  32'h0);
    checkOutput("midFillMissCnt", {16'h0, missCount}, 32'h0);
    addrQ.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, mk(0, 16'h0000, 16'h0, 1, 1, 16'h0000, 16'd1), 16'h0);

    // 4-way LRU: fill tags 0..3 in set 0, re-touch tag 1, tag 4 evicts tag 0.
    $display("[TB] 4-way LRU and saturation");
    for (int t = 0; t < 4; t++) begin
      v = mk(0, 16'(t << 10), 16'h0, 1, 1, 16'(t << 10), 16'(t + 1));
      applyStimulus(1'b1, v, 16'h0);
    end
    applyStimulus(1'b1, mk(0, 16'h0402, 16'h0, 0, 1, 16'h0402, 16'd4), 16'h0);
    applyStimulus(1'b1, mk(0, 16'h1000, 16'h0, 1, 1, 16'h1000, 16'd5), 16'h0);
    for (int t = 1; t < 5; t++) begin
      v = mk(0, 16'((t << 10) | 4), 16'h0, 0, 1, 16'((t << 10) | 4), 16'd5);
      applyStimulus(1'b1, v, 16'h0);
    end
    applyStimulus(1'b1, mk(0, 16'h0006, 16'h0, 1, 1, 16'h0006, 16'd6), 16'h0);

    @(negedge clk);
    force dut4.r_missCount = 16'hFFFE;
    @(negedge clk);
    release dut4.r_missCount;
    applyStimulus(1'b1, mk(0, 16'h1400, 16'h0, 1, 1, 16'h1400, 16'hFFFF), 16'h0);
    applyStimulus(1'b1, mk(0, 16'h1800, 16'h0, 1, 1, 16'h1800, 16'hFFFF), 16'h0);

    repeat (2) @(negedge clk);
    checkOutput("addrQueueDrained", addrQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
